// File: rtl/multi_pipe_param.sv
// multi_pipe_param: fully pipelined WIDTH x WIDTH integer multiplier.
// Stage 1 registers sign-corrected partial products; each following stage
// registers one level of a binary adder tree. A single global enable stalls
// the whole pipe when the output is held by the consumer.
module multi_pipe_param #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
  input  logic               signed_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul_out,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAT    = 1 + LEVELS;
  localparam int PW     = 2 * WIDTH;
  // Partial-product count padded to a power of two; extra leaves are zero.
  localparam int NPP    = 1 << LEVELS;
  // Adder tree stored as a heap: node 0 is the root (the product),
  // children of node i are 2i+1 and 2i+2, leaves start at NPP-1.
  localparam int NODES  = 2 * NPP - 1;

  logic              en;
  logic [LAT-1:0]    vld_q;
  logic [TAG_W-1:0]  tag_q [LAT];
  logic [PW-1:0]     node_q [NODES];
  logic [PW-1:0]     node_d [NODES];
  logic [NODES-1:0]  load;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     pp [NPP];

  // Whole pipe advances unless a result is waiting on a stalled consumer.
  assign en        = !vld_q[LAT-1] || out_ready;
  assign in_ready  = rst_n && en;
  assign out_valid = vld_q[LAT-1];
  assign mul_out   = node_q[0];
  assign out_tag   = tag_q[LAT-1];

  // Partial products; the mode bit is fully consumed here because the MSB
  // row is negated for two's complement, so later stages only add.
  always_comb begin
    a_ext = signed_mode ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a}
                        : {{WIDTH{1'b0}}, mul_a};
    for (int j = 0; j < NPP; j++) pp[j] = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (mul_b[j]) begin
        if (signed_mode && (j == WIDTH - 1)) pp[j] = '0 - (a_ext << j);
        else                                 pp[j] = a_ext << j;
      end
    end
  end

  // Next value and load strobe for every tree node, level by level.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      node_d[i] = '0;
      load[i]   = 1'b0;
    end
    for (int s = 0; s < LAT; s++) begin
      for (int k = 0; k < NPP; k++) begin
        if (k < (NPP >> s)) begin
          if (s == 0) begin
            node_d[NPP-1+k] = pp[k];
            load[NPP-1+k]   = en && in_valid;
          end else begin
            node_d[(NPP>>s)-1+k] = node_q[(NPP>>(s-1))-1+2*k]
                                 + node_q[(NPP>>(s-1))+2*k];
            load[(NPP>>s)-1+k]   = en && vld_q[s-1];
          end
        end
      end
    end
  end

  // Tree registers load only when a valid operand enters their level, so
  // the output holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) node_q[i] <= '0;
    end else begin
      for (int i = 0; i < NODES; i++) begin
        if (load[i]) node_q[i] <= node_d[i];
      end
    end
  end

  // Per-stage valid and tag travel alongside the tree levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else if (en) begin
      vld_q <= {vld_q[LAT-2:0], in_valid};
      if (in_valid) tag_q[0] <= in_tag;
      for (int s = 1; s < LAT; s++) begin
        if (vld_q[s-1]) tag_q[s] <= tag_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_multi_pipe_param.sv
// Testbench for multi_pipe_param: a WIDTH=8 instance exercised with directed
// corners, streaming, back-pressure and reset; WIDTH=4/5/32 instances swept.
module tb_multi_pipe_param;

  logic clk, rst_n;
  int   ntests = 0;
  int   nfail  = 0;

  // WIDTH=8 instance
  logic        iv8, ir8, m8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [3:0]  t8, ot8;
  logic [15:0] mo8;

  // sweep instances share control
  logic        ivs, ors, ms;
  logic [3:0]  ts;
  logic [3:0]  a4, b4;
  logic [4:0]  a5, b5;
  logic [31:0] a32, b32;
  logic        ir4, ir5, ir32, ov4, ov5, ov32;
  logic [7:0]  mo4;
  logic [9:0]  mo5;
  logic [63:0] mo32;
  logic [3:0]  ot4, ot5, ot32;

  multi_pipe_param #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .mul_a(a8), .mul_b(b8),
    .signed_mode(m8), .in_tag(t8), .out_valid(ov8), .out_ready(or8), .mul_out(mo8), .out_tag(ot8));
  multi_pipe_param #(.WIDTH(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivs), .in_ready(ir4), .mul_a(a4), .mul_b(b4),
    .signed_mode(ms), .in_tag(ts), .out_valid(ov4), .out_ready(ors), .mul_out(mo4), .out_tag(ot4));
  multi_pipe_param #(.WIDTH(5), .TAG_W(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivs), .in_ready(ir5), .mul_a(a5), .mul_b(b5),
    .signed_mode(ms), .in_tag(ts), .out_valid(ov5), .out_ready(ors), .mul_out(mo5), .out_tag(ot5));
  multi_pipe_param #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivs), .in_ready(ir32), .mul_a(a32), .mul_b(b32),
    .signed_mode(ms), .in_tag(ts), .out_valid(ov32), .out_ready(ors), .mul_out(mo32), .out_tag(ot32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact product of the low w bits of a and b, reduced to 2*w bits.
  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic s, int w);
    logic [63:0] msk, am, bm, p;
    longint      av, bv;
    msk = (w >= 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
    am  = {32'd0, a} & msk;
    bm  = {32'd0, b} & msk;
    av  = longint'(am);
    bv  = longint'(bm);
    if (s && am[w-1]) av = av - (longint'(1) << w);
    if (s && bm[w-1]) bv = bv - (longint'(1) << w);
    p = 64'(av * bv);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // WIDTH=8 reference: ops accepted in order, each emerges after 4 enabled
  // edges (counting the accepting edge); the output holds between results.
  bit          mv [4];
  logic [15:0] mp [4];
  logic [3:0]  mt [4];
  logic [15:0] eo, cur_exp, held;
  logic [3:0]  et, heldt;

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin mv[i] = 0; mp[i] = '0; mt[i] = '0; end
    eo = '0; et = '0;
  endtask

  task automatic drive8(bit v, logic [7:0] a, logic [7:0] b, bit m, logic [3:0] t, logic [15:0] e);
    iv8 = v; a8 = a; b8 = b; m8 = m; t8 = t; cur_exp = e;
  endtask

  task automatic drive8r(bit v, logic [3:0] t);
    logic [7:0]  a, b;
    logic        m;
    logic [63:0] p;
    a = 8'($urandom); b = 8'($urandom); m = 1'($urandom_range(0, 1));
    p = ref_mul(32'(a), 32'(b), m, 8);
    drive8(v, a, b, m, t, p[15:0]);
  endtask

  task automatic idle8();
    drive8(0, 8'h00, 8'h00, 0, 4'h0, 16'h0000);
  endtask

  task automatic step8();
    bit en;
    #1;
    en = !mv[3] || or8;
    chk("in_ready", 64'(ir8), 64'(en));
    @(posedge clk);
    if (en) begin
      for (int i = 3; i > 0; i--) begin mv[i] = mv[i-1]; mp[i] = mp[i-1]; mt[i] = mt[i-1]; end
      mv[0] = iv8; mp[0] = cur_exp; mt[0] = t8;
      if (mv[3]) begin eo = mp[3]; et = mt[3]; end
    end
    #1;
    chk("out_valid", 64'(ov8), 64'(mv[3]));
    chk("mul_out", 64'(mo8), 64'(eo));
    chk("out_tag", 64'(ot8), 64'(et));
  endtask

  logic [7:0]  ca [5] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'hFF};
  logic [7:0]  cb [5] = '{8'hAB, 8'h80, 8'h01, 8'h80, 8'hFF};
  bit          cm [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] cp [5] = '{16'h0000, 16'h4000, 16'hFFFF, 16'hC080, 16'h0001};

  int lat, first, cnt, n4, n5, n32;
  logic [3:0]  etag;
  logic [67:0] q4 [$];
  logic [67:0] q5 [$];
  logic [67:0] q32 [$];
  logic [67:0] ex;

  initial begin
    rst_n = 1'b1; or8 = 1'b1; ors = 1'b1; ivs = 1'b0; ms = 1'b0; ts = '0;
    a4 = '0; b4 = '0; a5 = '0; b5 = '0; a32 = '0; b32 = '0;
    idle8(); mreset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", 64'(ov8), 64'd0);
    chk("reset mul_out", 64'(mo8), 64'd0);
    chk("reset out_tag", 64'(ot8), 64'd0);
    chk("reset in_ready", 64'(ir8), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // unsigned corner with latency measurement
    drive8(1, 8'hFF, 8'hFF, 0, 4'h3, 16'hFE01);
    step8(); idle8(); lat = 1;
    while (!ov8 && lat < 12) begin step8(); lat++; end
    chk("latency", 64'(lat), 64'd4);
    step8();

    // corner table back-to-back, then drain
    for (int i = 0; i < 5; i++) begin drive8(1, ca[i], cb[i], cm[i], 4'(i + 1), cp[i]); step8(); end
    idle8();
    for (int i = 0; i < 6; i++) step8();

    // 16 back-to-back mixed-mode ops, tags 0..15
    first = 0; cnt = 0; etag = '0;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) drive8r(1, 4'(i)); else idle8();
      step8();
      if (ov8) begin
        if (first == 0) first = i + 1;
        cnt++;
        chk("stream tag order", 64'(ot8), 64'(etag));
        etag++;
      end
    end
    chk("stream first valid edge", 64'(first), 64'd4);
    chk("stream count", 64'(cnt), 64'd16);

    // back-pressure on a full pipe
    for (int i = 0; i < 6; i++) begin drive8r(1, 4'(i)); step8(); end
    or8 = 1'b0; held = mo8; heldt = ot8;
    for (int i = 0; i < 5; i++) begin
      drive8r(1, 4'(i + 8)); step8();
      chk("stall mul_out held", 64'(mo8), 64'(held));
      chk("stall out_tag held", 64'(ot8), 64'(heldt));
    end
    or8 = 1'b1;
    for (int i = 0; i < 4; i++) begin drive8r(1, 4'(i + 3)); step8(); end
    idle8();
    for (int i = 0; i < 6; i++) step8();

    // random valid / ready interplay
    for (int i = 0; i < 80; i++) begin
      drive8r(1'($urandom_range(0, 1)), 4'(i));
      or8 = 1'($urandom_range(0, 1));
      step8();
    end
    or8 = 1'b1; idle8();
    for (int i = 0; i < 6; i++) step8();

    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin drive8r(1, 4'(i + 9)); step8(); end
    idle8();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 64'(ov8), 64'd0);
    chk("midreset mul_out", 64'(mo8), 64'd0);
    chk("midreset out_tag", 64'(ot8), 64'd0);
    chk("midreset in_ready", 64'(ir8), 64'd0);
    mreset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step8();
    drive8(1, 8'h12, 8'h34, 0, 4'hA, 16'h03A8);
    step8(); idle8(); lat = 1;
    while (!ov8 && lat < 12) begin step8(); lat++; end
    chk("post-reset latency", 64'(lat), 64'd4);
    step8();

    // parameter sweep: WIDTH=4 exhaustive both modes, WIDTH=5/32 random
    n4 = 0; n5 = 0; n32 = 0;
    for (int n = 0; n < 530; n++) begin
      if (n < 512) begin
        ivs = 1'b1; ms = n[8]; ts = 4'(n);
        a4 = n[7:4]; b4 = n[3:0];
        a5 = 5'($urandom); b5 = 5'($urandom);
        a32 = $urandom; b32 = $urandom;
      end else ivs = 1'b0;
      #1;
      if (ivs && ir4)  begin q4.push_back({ts, ref_mul(32'(a4), 32'(b4), ms, 4)}); n4++; end
      if (ivs && ir5)  begin q5.push_back({ts, ref_mul(32'(a5), 32'(b5), ms, 5)}); n5++; end
      if (ivs && ir32) begin q32.push_back({ts, ref_mul(a32, b32, ms, 32)}); n32++; end
      @(posedge clk); #1;
      if (ov4) begin
        chk("w4 unexpected output", 64'(q4.size() != 0), 64'd1);
        if (q4.size() != 0) begin
          ex = q4.pop_front();
          chk("w4 product", 64'(mo4), ex[63:0]); chk("w4 tag", 64'(ot4), 64'(ex[67:64]));
        end
      end
      if (ov5) begin
        chk("w5 unexpected output", 64'(q5.size() != 0), 64'd1);
        if (q5.size() != 0) begin
          ex = q5.pop_front();
          chk("w5 product", 64'(mo5), ex[63:0]); chk("w5 tag", 64'(ot5), 64'(ex[67:64]));
        end
      end
      if (ov32) begin
        chk("w32 unexpected output", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          ex = q32.pop_front();
          chk("w32 product", mo32, ex[63:0]); chk("w32 tag", 64'(ot32), 64'(ex[67:64]));
        end
      end
    end
    chk("w4 accepted", 64'(n4), 64'd512);
    chk("w5 accepted", 64'(n5), 64'd512);
    chk("w32 accepted", 64'(n32), 64'd512);
    chk("w4 drained", 64'(q4.size()), 64'd0);
    chk("w5 drained", 64'(q5.size()), 64'd0);
    chk("w32 drained", 64'(q32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
